conv_encoder_ctrl: RTL and testbench

//  Frame sequencer for the convolutional encoder. Accepts one 128-bit information frame plus config
//  (generator polynomials, code rate) over a valid/ready handshake, initialises the encoder, serialises
//  the frame MSB-first into it, waits for encoder done, then presents the 384-bit codeword downstream.

---
 rtl/conv_enc_ctrl_pkg.sv | 26 ++
 rtl/enc_tx_serializer.sv | 32 +++
 rtl/conv_encoder_ctrl.sv | 117 +++++++++++
 tb/tb_conv_encoder_ctrl.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/conv_enc_ctrl_pkg.sv
// conv_enc_ctrl_pkg: shared constants and state type for conv_encoder_ctrl (CONV_ENC_CTRL_WDOG_EN enables its DRAIN watchdog).
// Code-rate encodings and K/NPOLY come from param_def.sv; the fallbacks below apply only when it is not loaded.
`ifndef MAX_CONSTRAINT_LENGTH
`define MAX_CONSTRAINT_LENGTH 9
`endif
`ifndef MAX_CODE_RATE
`define MAX_CODE_RATE 3
`endif
`ifndef CODE_RATE_2
`define CODE_RATE_2 1'b0
`endif
`ifndef CODE_RATE_3
`define CODE_RATE_3 1'b1
`endif
package conv_enc_ctrl_pkg;
  localparam int FRAME_LEN = 128;
  localparam int BIT_W = $clog2(FRAME_LEN);
  localparam int CW_W = 384;
  localparam int CNT_W = 16;
  localparam int K = `MAX_CONSTRAINT_LENGTH;
  localparam int NPOLY = `MAX_CODE_RATE;
  localparam int PW = K * NPOLY;
  localparam logic CODE_RATE_2 = `CODE_RATE_2;
  localparam logic CODE_RATE_3 = `CODE_RATE_3;
  typedef enum logic [2:0] {IDLE, INIT, RUN, DRAIN, OUT} state_t;
endpackage

// File: rtl/enc_tx_serializer.sv
// enc_tx_serializer: MSB-first frame shifter with registered output bit and a per-bit index counter.
module enc_tx_serializer import conv_enc_ctrl_pkg::*; (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_load,
  input  logic [FRAME_LEN-1:0] i_frame,
  input  logic                 i_shift,
  output logic                 o_bit,
  output logic                 o_last
);
  logic [FRAME_LEN-1:0] r_sr;
  logic [BIT_W-1:0]     r_cnt;
  logic                 r_bit;
  // counter preloads all-ones so the first shift lands on index 0 for the first transmitted bit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sr  <= '0;
      r_cnt <= '0;
      r_bit <= 1'b0;
    end else if (i_load) begin
      r_sr  <= i_frame;
      r_cnt <= '1;
      r_bit <= 1'b0;
    end else if (i_shift) begin
      r_sr  <= {r_sr[FRAME_LEN-2:0], 1'b0};
      r_cnt <= r_cnt + 1'b1;
      r_bit <= r_sr[FRAME_LEN-1];
    end
  end
  assign o_bit  = r_bit;
  assign o_last = &r_cnt;
endmodule

// File: rtl/conv_encoder_ctrl.sv
// conv_encoder_ctrl: frame sequencer feeding the convolutional encoder and buffering one codeword.
// Define CONV_ENC_CTRL_WDOG_EN to abort a DRAIN that sees no encoder done within WDOG_CYC cycles.
module conv_encoder_ctrl import conv_enc_ctrl_pkg::*; (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [FRAME_LEN-1:0] i_frame_data,
  input  logic [PW-1:0]        i_gen_poly,
  input  logic                 i_code_rate,
  input  logic                 i_frame_valid,
  output logic                 o_frame_ready,
  output logic                 o_enc_rst,
  output logic                 o_en_ce,
  output logic [PW-1:0]        o_gen_poly,
  output logic                 o_code_rate,
  output logic                 o_tx_data,
  input  logic [CW_W-1:0]      i_encoder_data,
  input  logic                 i_encoder_done,
  output logic [CW_W-1:0]      o_cw_data,
  output logic                 o_cw_rate,
  output logic                 o_cw_valid,
  input  logic                 i_cw_ready,
  output logic                 o_busy,
  output logic                 o_err,
  output logic [CNT_W-1:0]     o_frame_cnt
);
  localparam logic [CW_W-1:0] HALF_MASK = {{(2*FRAME_LEN){1'b1}}, {(CW_W-2*FRAME_LEN){1'b0}}};
`ifdef CONV_ENC_CTRL_WDOG_EN
  localparam int WDOG_CYC = 16;
  localparam int WD_W = $clog2(WDOG_CYC);
  localparam logic [WD_W-1:0] WDOG_LAST = WD_W'(WDOG_CYC - 1);
  logic [WD_W-1:0] r_wdog;
`endif
  state_t r_state;
  logic   w_accept, w_shift, w_last;
  assign w_accept = o_frame_ready & i_frame_valid;
  assign w_shift  = (r_state == INIT) | (r_state == RUN);
  enc_tx_serializer u_ser (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_accept),
    .i_frame (i_frame_data),
    .i_shift (w_shift),
    .o_bit   (o_tx_data),
    .o_last  (w_last)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= IDLE;
      o_frame_ready <= 1'b0;
      o_enc_rst     <= 1'b0;
      o_en_ce       <= 1'b0;
      o_gen_poly    <= '0;
      o_code_rate   <= 1'b0;
      o_cw_data     <= '0;
      o_cw_rate     <= 1'b0;
      o_cw_valid    <= 1'b0;
      o_busy        <= 1'b0;
      o_err         <= 1'b0;
      o_frame_cnt   <= '0;
`ifdef CONV_ENC_CTRL_WDOG_EN
      r_wdog        <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: if (w_accept) begin
          r_state       <= INIT;
          o_frame_ready <= 1'b0;
          o_busy        <= 1'b1;
          o_gen_poly    <= i_gen_poly;
          o_code_rate   <= i_code_rate;
        end else begin
          o_frame_ready <= 1'b1;
        end
        INIT: begin
          r_state   <= RUN;
          o_enc_rst <= 1'b1;
          o_en_ce   <= 1'b1;
        end
        RUN: begin
          if (i_encoder_done) o_err <= 1'b1;
          if (w_last) r_state <= DRAIN;
`ifdef CONV_ENC_CTRL_WDOG_EN
          r_wdog <= '0;
`endif
        end
        DRAIN: if (i_encoder_done) begin
          r_state    <= OUT;
          o_en_ce    <= 1'b0;
          o_cw_valid <= 1'b1;
          o_cw_rate  <= o_code_rate;
          o_cw_data  <= (o_code_rate == CODE_RATE_2) ? (i_encoder_data & HALF_MASK) : i_encoder_data;
        end
`ifdef CONV_ENC_CTRL_WDOG_EN
        else if (r_wdog == WDOG_LAST) begin
          r_state       <= IDLE;
          o_err         <= 1'b1;
          o_en_ce       <= 1'b0;
          o_enc_rst     <= 1'b0;
          o_busy        <= 1'b0;
          o_frame_ready <= 1'b1;
        end else begin
          r_wdog <= r_wdog + 1'b1;
        end
`endif
        OUT: if (i_cw_ready) begin
          r_state       <= IDLE;
          o_cw_valid    <= 1'b0;
          o_frame_cnt   <= o_frame_cnt + 1'b1;
          o_enc_rst     <= 1'b0;
          o_busy        <= 1'b0;
          o_frame_ready <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_conv_encoder_ctrl.sv
// tb_conv_encoder_ctrl: randomized frames through conv_encoder_ctrl with a behavioural encoder stand-in and codeword model.
module tb_conv_encoder_ctrl;
  import conv_enc_ctrl_pkg::*;
  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic [FRAME_LEN-1:0] i_frame_data = '0;
  logic [PW-1:0]        i_gen_poly = '0;
  logic                 i_code_rate = 1'b0;
  logic                 i_frame_valid = 1'b0;
  logic                 o_frame_ready, o_enc_rst, o_en_ce, o_code_rate, o_tx_data;
  logic [PW-1:0]        o_gen_poly;
  logic [CW_W-1:0]      i_encoder_data = '0;
  logic                 i_encoder_done = 1'b0;
  logic [CW_W-1:0]      o_cw_data;
  logic                 o_cw_rate, o_cw_valid, o_busy, o_err;
  logic                 i_cw_ready = 1'b0;
  logic [CNT_W-1:0]     o_frame_cnt;
  int n_chk = 0;
  int n_fail = 0;
  logic [CNT_W-1:0] exp_cnt = '0;
  logic             exp_err = 1'b0;

  always #5 clk = ~clk;

  conv_encoder_ctrl dut (
    .clk(clk), .rst(rst), .i_frame_data(i_frame_data), .i_gen_poly(i_gen_poly),
    .i_code_rate(i_code_rate), .i_frame_valid(i_frame_valid), .o_frame_ready(o_frame_ready),
    .o_enc_rst(o_enc_rst), .o_en_ce(o_en_ce), .o_gen_poly(o_gen_poly), .o_code_rate(o_code_rate),
    .o_tx_data(o_tx_data), .i_encoder_data(i_encoder_data), .i_encoder_done(i_encoder_done),
    .o_cw_data(o_cw_data), .o_cw_rate(o_cw_rate), .o_cw_valid(o_cw_valid), .i_cw_ready(i_cw_ready),
    .o_busy(o_busy), .o_err(o_err), .o_frame_cnt(o_frame_cnt)
  );

  task automatic chk(input string tag, input logic [CW_W-1:0] got, input logic [CW_W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [FRAME_LEN-1:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Reference convolutional code: per info bit, one parity per polynomial packed MSB-first.
  function automatic logic [CW_W-1:0] ref_cw(input logic [FRAME_LEN-1:0] f, input logic [PW-1:0] poly, input logic rate);
    logic [K-1:0]    sh = '0;
    logic [CW_W-1:0] cw = '0;
    int n = (rate == CODE_RATE_3) ? 3 : 2;
    for (int i = 0; i < FRAME_LEN; i++) begin
      sh = {sh[K-2:0], f[FRAME_LEN-1-i]};
      for (int j = 0; j < n; j++) cw[CW_W-1-n*i-j] = ^(sh & poly[K*j +: K]);
    end
    return cw;
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, "_ready"}, o_frame_ready, 0);
    chk({tag, "_enc_rst"}, o_enc_rst, 0);
    chk({tag, "_en_ce"}, o_en_ce, 0);
    chk({tag, "_tx"}, o_tx_data, 0);
    chk({tag, "_cw"}, {o_cw_valid, o_cw_rate, o_code_rate, o_busy, o_err}, 0);
    chk({tag, "_cw_data"}, o_cw_data, 0);
    chk({tag, "_poly"}, o_gen_poly, 0);
    chk({tag, "_cnt"}, o_frame_cnt, 0);
  endtask

  // drain_d: DRAIN cycles before done (0 = never); done_bit/abort_bit: RUN bit index or -1.
  task automatic run_frame(input logic [FRAME_LEN-1:0] f, input logic [PW-1:0] poly, input logic rate,
                           input int drain_d, input int hold, input int done_bit, input int abort_bit);
    logic [FRAME_LEN-1:0] cap = '0;
    logic [CW_W-1:0]      exp_cw;
    int bad = 0;
    int w = 0;
    while (!o_frame_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("ready_wait", o_frame_ready, 1);
    i_frame_data = f; i_gen_poly = poly; i_code_rate = rate; i_frame_valid = 1'b1;
    @(negedge clk);
    i_frame_valid = 1'b0; i_frame_data = rand128(); i_gen_poly = ~poly; i_code_rate = ~rate;
    chk("init_ready", o_frame_ready, 0);
    chk("init_ctl", {o_busy, o_enc_rst, o_en_ce}, 3'b100);
    chk("init_cfg", {o_gen_poly, o_code_rate}, {poly, rate});
    for (int i = 0; i < FRAME_LEN; i++) begin
      @(negedge clk);
      if (i == abort_bit) begin
        rst = 1'b0;
        i_frame_valid = 1'b0; i_encoder_done = 1'b0;
        #1;
        chk_reset("abort");
        exp_cnt = '0; exp_err = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        return;
      end
      cap[FRAME_LEN-1-i] = o_tx_data;
      if (!(o_en_ce && o_enc_rst && o_busy && !o_frame_ready)) bad++;
      i_frame_valid = 1'($urandom_range(0, 1));
      i_encoder_done = (i == done_bit);
      if (i == done_bit) exp_err = 1'b1;
    end
    i_encoder_done = 1'b0; i_frame_valid = 1'b0;
    chk("run_bits", cap, f);
    chk("run_ctl", bad, 0);
    @(negedge clk);
    chk("drain_tx", o_tx_data, 0);
    chk("drain_ce", {o_en_ce, o_cw_valid}, 2'b10);
`ifdef CONV_ENC_CTRL_WDOG_EN
    if (drain_d == 0) begin
      bad = 0;
      for (int d = 1; d < 16; d++) begin
        @(negedge clk);
        if (!(o_en_ce && o_busy && !o_cw_valid)) bad++;
      end
      chk("wdog_wait", bad, 0);
      @(negedge clk);
      exp_err = 1'b1;
      chk("wdog_idle", {o_frame_ready, o_busy, o_en_ce, o_cw_valid}, 4'b1000);
      chk("wdog_err", o_err, exp_err);
      chk("wdog_cnt", o_frame_cnt, exp_cnt);
      return;
    end
`endif
    for (int d = 0; d < drain_d; d++) begin
      if (d > 0) @(negedge clk);
      i_encoder_done = (d == drain_d - 1);
      i_encoder_data = (d == drain_d - 1) ?
        (ref_cw(cap, o_gen_poly, o_code_rate) | ((o_code_rate == CODE_RATE_2) ? {256'b0, rand128()} : '0)) :
        {rand128(), rand128(), rand128()};
    end
    @(negedge clk);
    i_encoder_done = 1'b0; i_encoder_data = {rand128(), rand128(), rand128()};
    exp_cw = ref_cw(f, poly, rate);
    chk("cw_valid", o_cw_valid, 1);
    chk("cw_data", o_cw_data, exp_cw);
    chk("cw_rate", o_cw_rate, rate);
    chk("out_ce", o_en_ce, 0);
    chk("err", o_err, exp_err);
    bad = 0;
    for (int h = 0; h < hold; h++) begin
      i_cw_ready = 1'b0; i_frame_valid = 1'b1;
      @(negedge clk);
      if (o_cw_valid !== 1'b1 || o_cw_data !== exp_cw || o_frame_ready !== 1'b0 || o_busy !== 1'b1) bad++;
    end
    chk("hold_stable", bad, 0);
    i_cw_ready = 1'b1; i_frame_valid = 1'b1;
    @(negedge clk);
    i_cw_ready = 1'b0; i_frame_valid = 1'b0;
    exp_cnt++;
    chk("cw_drop", o_cw_valid, 0);
    chk("frame_cnt", o_frame_cnt, exp_cnt);
    chk("idle_state", {o_busy, o_frame_ready, o_enc_rst}, 3'b010);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_reset("reset");
    rst = 1'b1;
    run_frame({1'b1, 126'b0, 1'b1}, {9'o557, 9'o663, 9'o711}, CODE_RATE_3, 3, 0, -1, -1);
    run_frame('1, PW'($urandom()), CODE_RATE_2, 2, 0, -1, -1);
    run_frame(rand128(), PW'($urandom()), CODE_RATE_3, 1, 20, -1, -1);
    run_frame(rand128(), PW'($urandom()), CODE_RATE_3, 4, 0, -1, 60);
    run_frame(rand128(), {9'o557, 9'o663, 9'o711}, CODE_RATE_3, 2, 1, -1, -1);
    for (int n = 0; n < 5; n++)
      run_frame(rand128(), PW'($urandom()), 1'($urandom_range(0, 1)), $urandom_range(1, 6), $urandom_range(0, 3), -1, -1);
`ifdef CONV_ENC_CTRL_WDOG_EN
    run_frame(rand128(), PW'($urandom()), CODE_RATE_3, 0, 0, -1, -1);
`endif
    run_frame(rand128(), PW'($urandom()), CODE_RATE_2, 2, 0, 10, -1);
    run_frame(rand128(), PW'($urandom()), CODE_RATE_3, 3, 2, -1, -1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
